neck_cut_sequencer: RTL

NECK_CUT_SEQUENCER -- requirements
Module: neck_cut_sequencer

---
 rtl/neck_pkg.sv | 29 ++
 rtl/neck_timer.sv | 33 +++
 rtl/neck_cut_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/neck_pkg.sv
// neck_pkg -- shared types and constants for the neck cut sequencer.
//   state_t      : FSM state encoding, also driven out on state_o
//   STATE_W      : width of state_o
//   STAT_W       : width of the cut/timeout statistics counters
//   timer_width(): bits needed by the shared cycle timer
package neck_pkg;

   localparam int STATE_W = 3;
   localparam int STAT_W  = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CUT     = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   // The timer only ever has to hold values up to (largest interval - 1),
   // so clog2 of the largest interval is enough; never less than one bit.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/neck_timer.sv
// neck_timer -- loadable up-counter with terminal-count compare.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   load  : synchronous reload of count to zero (wins over en)
//   en    : count up by one
//   term  : terminal value to compare against
//   count : current count
//   tc    : high while count equals term
module neck_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == term);

endmodule

// File: rtl/neck_cut_sequencer.sv
// neck_cut_sequencer -- arms on a stable arc, cuts welding current on a
// neck-onset pulse, ends the cut on short detection or a cut-length limit,
// blanks detection afterwards and latches a fault after repeated timeouts.
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   ctl_switch    : operator enable; 0 forces IDLE from any state
//   arc_on        : arc present
//   neck_det      : single-cycle neck-onset pulse
//   short_det     : short-circuit / droplet-transfer level
//   judge_en      : enables the neck judge datapath (ARMED only)
//   power_switch  : 1 = IGBT off (current cut), high only in CUT
//   state_o       : current state encoding (neck_pkg::state_t)
//   cut_timeout   : one-cycle pulse when a cut ends on the CUT_MAX limit
//   fault         : high while in FAULT
//   cut_cnt, timeout_cnt : saturating event statistics
// Optional feature macro: NECK_STATS_EN builds the statistics counters;
// without it both statistics outputs are tied to zero.
// All outputs are registered.
module neck_cut_sequencer
   import neck_pkg::*;
#(
   parameter int ARM_DLY = 1000,
   parameter int CUT_MAX = 100000,
   parameter int HOLDOFF = 5000000,
   parameter int FAULT_N = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ctl_switch,
   input  logic               arc_on,
   input  logic               neck_det,
   input  logic               short_det,
   output logic               judge_en,
   output logic               power_switch,
   output logic [STATE_W-1:0] state_o,
   output logic               cut_timeout,
   output logic               fault,
   output logic [STAT_W-1:0]  cut_cnt,
   output logic [STAT_W-1:0]  timeout_cnt
);

   localparam int TW = timer_width(ARM_DLY, CUT_MAX, HOLDOFF);
   localparam int FW = $clog2(FAULT_N + 1);

   state_t          state;
   state_t          next_state;
   logic [TW-1:0]   timer_term;
   logic [TW-1:0]   timer_count;
   logic            timer_tc;
   logic            timer_load;
   logic            timer_en;
   logic            timeout_evt;
   logic [FW-1:0]   to_run;
   logic [FW-1:0]   to_run_next;
   logic [FW-1:0]   to_run_inc;

   neck_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .en    (timer_en),
      .term  (timer_term),
      .count (timer_count),
      .tc    (timer_tc)
   );

   assign to_run_inc = to_run + FW'(1);

   always_comb begin
      next_state  = state;
      timer_term  = '0;
      timer_en    = 1'b0;
      timeout_evt = 1'b0;
      to_run_next = to_run;

      case (state)
         ST_IDLE: begin
            // Timer counts consecutive arc_on cycles; a dropout reloads it.
            timer_term = TW'(ARM_DLY - 1);
            timer_en   = arc_on;
            if (arc_on && timer_tc) next_state = ST_ARMED;
         end
         ST_ARMED: begin
            // Losing the arc outranks a neck pulse in the same cycle.
            if (!arc_on)       next_state = ST_IDLE;
            else if (neck_det) next_state = ST_CUT;
         end
         ST_CUT: begin
            timer_term = TW'(CUT_MAX - 1);
            timer_en   = 1'b1;
            if (short_det) begin
               // Normal end wins over a coincident timeout.
               next_state  = ST_HOLDOFF;
               to_run_next = '0;
            end else if (timer_tc) begin
               timeout_evt = 1'b1;
               to_run_next = to_run_inc;
               next_state  = (to_run_inc == FW'(FAULT_N)) ? ST_FAULT : ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            timer_term = TW'(HOLDOFF - 1);
            timer_en   = 1'b1;
            if (timer_tc) next_state = arc_on ? ST_ARMED : ST_IDLE;
         end
         ST_FAULT: begin
            next_state = ST_FAULT;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase

      // Operator disable overrides everything and also forgets the
      // timeout history, so re-enabling starts from a clean slate.
      if (!ctl_switch) begin
         next_state  = ST_IDLE;
         timer_en    = 1'b0;
         timeout_evt = 1'b0;
         to_run_next = '0;
      end

      timer_load = (next_state != state) || !ctl_switch ||
                   ((state == ST_IDLE) && !arc_on);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         power_switch <= 1'b0;
         judge_en     <= 1'b0;
         fault        <= 1'b0;
         cut_timeout  <= 1'b0;
         to_run       <= '0;
      end else begin
         state        <= next_state;
         power_switch <= (next_state == ST_CUT);
         judge_en     <= (next_state == ST_ARMED);
         fault        <= (next_state == ST_FAULT);
         cut_timeout  <= timeout_evt;
         to_run       <= to_run_next;
      end
   end

   assign state_o = state;

`ifdef NECK_STATS_EN
   logic cut_entry;
   assign cut_entry = (next_state == ST_CUT) && (state != ST_CUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cut_cnt     <= '0;
         timeout_cnt <= '0;
      end else begin
         if (cut_entry && (cut_cnt != '1))
            cut_cnt <= cut_cnt + STAT_W'(1);
         if (timeout_evt && (timeout_cnt != '1))
            timeout_cnt <= timeout_cnt + STAT_W'(1);
      end
   end
`else
   assign cut_cnt     = '0;
   assign timeout_cnt = '0;
`endif

endmodule
